// File: rtl/cp0_regfile_irq.sv
// cp0_regfile_irq
//   MIPS-style coprocessor-0 register subset with timer and interrupt logic.
//   Implemented registers: BadVAddr(8), Count(9), Compare(11), Status(12),
//   Cause(13), EPC(14). Every other register number reads as zero.
//
// Ports
//   clk, rst      : clock and synchronous active-high reset
//   hw_int        : level-sensitive hardware interrupt lines (N_HWINT wide)
//   exc_valid     : an exception or ERET commits this cycle
//   exc_code      : ExcCode of the committing exception, 5'h1F = ERET
//   exc_bd        : faulting instruction sits in a branch delay slot
//   exc_pc        : PC of the faulting instruction
//   exc_badvaddr  : faulting address (captured for AdEL/AdES only)
//   mtc0_we       : MTC0 write strobe
//   mtc0_addr     : MTC0 destination register number
//   mtc0_wdata    : MTC0 write data
//   rd_addr       : MFC0 register number
//   rd_data       : combinational MFC0 read data
//   epc, status, cause : direct register views
//   irq_pending   : an enabled interrupt is pending and may be taken
module cp0_regfile_irq #(
    parameter int N_HWINT   = 6,
    parameter int COUNT_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_HWINT-1:0] hw_int,
    input  logic               exc_valid,
    input  logic [4:0]         exc_code,
    input  logic               exc_bd,
    input  logic [31:0]        exc_pc,
    input  logic [31:0]        exc_badvaddr,
    input  logic               mtc0_we,
    input  logic [4:0]         mtc0_addr,
    input  logic [31:0]        mtc0_wdata,
    input  logic [4:0]         rd_addr,
    output logic [31:0]        rd_data,
    output logic [31:0]        epc,
    output logic [31:0]        status,
    output logic [31:0]        cause,
    output logic               irq_pending
);

    localparam logic [4:0] ERET_CODE   = 5'h1F;
    localparam logic [4:0] REG_BADVA   = 5'd8;
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [3:0] PRE_LAST    = 4'(COUNT_DIV - 1);

    // Architectural state
    logic [31:0] count;
    logic [3:0]  presc;
    logic [31:0] compare;
    logic [31:0] badvaddr;
    logic [31:0] epc_q;
    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic        ti;
    logic [5:0]  hw_q;
    logic [1:0]  ip_sw;
    logic [4:0]  exc_code_q;

    // Decoded events for this cycle
    logic        is_exc;
    logic        is_eret;
    logic        take_epc;
    logic        ld_badva;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        timer_match;
    logic [5:0]  hw_ext;
    logic [7:0]  ip;

    assign is_exc     = exc_valid && (exc_code != ERET_CODE);
    assign is_eret    = exc_valid && (exc_code == ERET_CODE);
    // EPC/BD are only captured for the outermost exception; nested ones
    // leave them alone so a concurrent MTC0 to EPC may still land.
    assign take_epc   = is_exc && !exl;
    assign ld_badva   = is_exc && ((exc_code == 5'd4) || (exc_code == 5'd5));

    assign wr_count   = mtc0_we && (mtc0_addr == REG_COUNT);
    assign wr_compare = mtc0_we && (mtc0_addr == REG_COMPARE);
    assign wr_status  = mtc0_we && (mtc0_addr == REG_STATUS);
    assign wr_cause   = mtc0_we && (mtc0_addr == REG_CAUSE);
    assign wr_epc     = mtc0_we && (mtc0_addr == REG_EPC);

    // Compared against the registered Count, so a Count load this cycle
    // cannot produce a match until the following edge.
    assign timer_match = (count == compare) && (compare != 32'd0);

    // Pad the interrupt lines out to the six IP[7:2] slots.
    always_comb begin
        hw_ext = '0;
        hw_ext[N_HWINT-1:0] = hw_int;
    end

    // IP[7] is shared between the timer and the sixth hardware line.
    assign ip = {hw_q[5] | ti, hw_q[4:0], ip_sw};

    assign status = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    assign cause  = {bd, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b00};
    assign epc    = epc_q;

    assign irq_pending = ie && !exl && (|(ip & im));

    always_comb begin
        rd_data = 32'd0;
        case (rd_addr)
            REG_BADVA:   rd_data = badvaddr;
            REG_COUNT:   rd_data = count;
            REG_COMPARE: rd_data = compare;
            REG_STATUS:  rd_data = status;
            REG_CAUSE:   rd_data = cause;
            REG_EPC:     rd_data = epc_q;
            default:     rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 32'd0;
            presc      <= 4'd0;
            compare    <= 32'd0;
            badvaddr   <= 32'd0;
            epc_q      <= 32'd0;
            im         <= 8'd0;
            exl        <= 1'b0;
            ie         <= 1'b0;
            bd         <= 1'b0;
            ti         <= 1'b0;
            hw_q       <= 6'd0;
            ip_sw      <= 2'd0;
            exc_code_q <= 5'd0;
        end else begin
            hw_q <= hw_ext;

            // Count load beats the prescaler tick and restarts the phase.
            if (wr_count) begin
                count <= mtc0_wdata;
                presc <= 4'd0;
            end else if (presc == PRE_LAST) begin
                count <= count + 32'd1;
                presc <= 4'd0;
            end else begin
                presc <= presc + 4'd1;
            end

            // Writing Compare acknowledges the timer and masks a same-cycle match.
            if (wr_compare) begin
                compare <= mtc0_wdata;
                ti      <= 1'b0;
            end else if (timer_match) begin
                ti <= 1'b1;
            end

            if (wr_cause) begin
                ip_sw <= mtc0_wdata[9:8];
            end

            if (wr_status) begin
                im  <= mtc0_wdata[15:8];
                ie  <= mtc0_wdata[0];
                exl <= mtc0_wdata[1];
            end
            // Later assignment wins: exception/ERET own EXL over MTC0.
            if (is_eret) begin
                exl <= 1'b0;
            end else if (is_exc) begin
                exl <= 1'b1;
            end

            if (is_exc) begin
                exc_code_q <= exc_code;
            end

            if (take_epc) begin
                epc_q <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
                bd    <= exc_bd;
            end else if (wr_epc) begin
                epc_q <= mtc0_wdata;
            end

            if (ld_badva) begin
                badvaddr <= exc_badvaddr;
            end
        end
    end

endmodule
